div_sequencer: RTL and testbench

Multi-cycle RV32M divide controller that time-shares the core's existing 32-bit ALU instead of owning a private subtractor. On `start` it requests the ALU from the EX-stage operand mux and stalls the pipeline. It then runs operand absolute-value, 32 restoring-division iterations and sign correction, all through the ALU's subtract path. It returns a quotient or remainder with a one-cycle `done` pulse. It sits beside the EX stage; the hazard unit treats `busy` as a stall source.

---
 rtl/divseq_pkg.sv | 18 +
 rtl/div_sequencer.sv | 123 ++++++++++++
 tb/tb_div_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/divseq_pkg.sv
// divseq_pkg: shared encodings for the ALU-sharing divide sequencer and EX-stage ALU control.
package divseq_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS_A,
    S_ABS_B,
    S_ITER,
    S_SIGN,
    S_DONE
  } state_e;
  localparam logic [1:0] OP_DIV = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  localparam logic [3:0] ALU_SEL_ADD = 4'b0010;
  localparam logic [3:0] ALU_SEL_SUB = 4'b0110;
  localparam int ITER_COUNT = 32;
endpackage

// File: rtl/div_sequencer.sv
// div_sequencer: RV32M divide controller that borrows the EX-stage ALU for restoring division.
// Define DIVSEQ_SIGNED_EN to enable signed DIV/REM (abs-value and sign-correction steps).
module div_sequencer #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [1:0]   op_i,
  input  logic [N-1:0] rs1_i,
  input  logic [N-1:0] rs2_i,
  input  logic         flush_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] result_o,
  output logic [N-1:0] alu_a_o,
  output logic [N-1:0] alu_b_o,
  output logic [3:0]   alu_sel_o,
  input  logic [N-1:0] alu_out_i,
  input  logic         alu_c_i
);
  import divseq_pkg::*;
`ifdef DIVSEQ_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif
  state_e state_q;
  logic [4:0] cnt_q;
  logic [1:0] op_q;
  logic [N-1:0] quo_q, rem_q, dvs_q, result_q;
  logic busy_q, done_q, neg_q_q, neg_r_q;
  logic sgn, ge;
  logic [N-1:0] shl, rem_d, quo_d, sel_val;
  always_comb begin
    sgn = SIGNED_EN & ~op_q[0];
    shl = {rem_q[N-2:0], quo_q[N-1]};
    // rem_q[N-1] set means the shifted value is >= 2^N, so it always exceeds the divisor
    ge = rem_q[N-1] | alu_c_i;
    rem_d = ge ? alu_out_i : shl;
    quo_d = {quo_q[N-2:0], ge};
    sel_val = op_q[1] ? rem_q : quo_q;
    alu_sel_o = busy_q ? ALU_SEL_SUB : ALU_SEL_ADD;
    alu_a_o = state_q == S_ITER ? shl : '0;
    alu_b_o = state_q == S_ABS_A ? quo_q :
              (state_q == S_ABS_B || state_q == S_ITER) ? dvs_q :
              state_q == S_SIGN ? sel_val : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      op_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      result_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (flush_i) begin
      state_q <= S_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start_i) begin
          op_q <= op_i;
          quo_q <= rs1_i;
          dvs_q <= rs2_i;
          rem_q <= '0;
          cnt_q <= '0;
          busy_q <= 1'b1;
          if (rs2_i == '0) begin
            state_q <= S_DONE;
            done_q <= 1'b1;
            result_q <= op_i[1] ? rs1_i : '1;
          end else state_q <= SIGNED_EN ? S_ABS_A : S_ITER;
        end
        S_ABS_A: begin
          if (sgn & quo_q[N-1]) quo_q <= alu_out_i;
          neg_q_q <= sgn & (quo_q[N-1] ^ dvs_q[N-1]);
          neg_r_q <= sgn & quo_q[N-1];
          state_q <= S_ABS_B;
        end
        S_ABS_B: begin
          if (sgn & dvs_q[N-1]) dvs_q <= alu_out_i;
          rem_q <= '0;
          state_q <= S_ITER;
        end
        S_ITER: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(ITER_COUNT - 1)) begin
            if (SIGNED_EN) state_q <= S_SIGN;
            else begin
              state_q <= S_DONE;
              done_q <= 1'b1;
              result_q <= op_q[1] ? rem_d : quo_d;
            end
          end
        end
        S_SIGN: begin
          result_q <= (op_q[1] ? neg_r_q : neg_q_q) ? alu_out_i : sel_val;
          done_q <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign result_o = result_q;
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed vector table plus flush/reset/ignored-start sequences for div_sequencer.
module tb_div_sequencer;
`ifdef DIVSEQ_SIGNED_EN
  localparam bit SGN = 1'b1;
  localparam int LAT = 36;
`else
  localparam bit SGN = 1'b0;
  localparam int LAT = 33;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0, alu_c;
  logic [1:0] op = 2'b00;
  logic [31:0] rs1 = '0, rs2 = '0, result, alu_a, alu_b, alu_out;
  logic busy, done;
  logic [3:0] alu_sel;
  logic [32:0] sub33, add33;
  int total = 0, passes = 0;
  logic [31:0] last_exp = '0;
  typedef struct {
    logic [1:0] op;
    logic [31:0] a, b, es, eu;
    bit poke;
  } vec_t;
  vec_t v[14];
  always #5 clk = ~clk;
  assign sub33 = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
  assign add33 = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_out = alu_sel == 4'b0110 ? sub33[31:0] : add33[31:0];
  assign alu_c = alu_sel == 4'b0110 ? sub33[32] : add33[32];
  div_sequencer dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .rs1_i(rs1), .rs2_i(rs2),
    .flush_i(flush), .busy_o(busy), .done_o(done), .result_o(result),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_sel_o(alu_sel),
    .alu_out_i(alu_out), .alu_c_i(alu_c)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, " busy"}, 32'(busy), 32'd0);
    chk({nm, " done"}, 32'(done), 32'd0);
    chk({nm, " result"}, result, 32'd0);
    chk({nm, " alu_a"}, alu_a, 32'd0);
    chk({nm, " alu_b"}, alu_b, 32'd0);
    chk({nm, " alu_sel"}, 32'(alu_sel), 32'h2);
  endtask
  task automatic run_op(input vec_t t, input string nm);
    int lat, seen;
    bit bz_ok;
    logic [31:0] exp, res;
    lat = t.b == 0 ? 1 : LAT;
    exp = SGN ? t.es : t.eu;
    seen = 0;
    bz_ok = 1'b1;
    res = 'x;
    @(negedge clk);
    start = 1'b1; op = t.op; rs1 = t.a; rs2 = t.b;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= lat + 1; c++) begin
      if (t.poke && c == 5) begin start = 1'b1; rs1 = 32'd999; rs2 = 32'd1; end
      else start = 1'b0;
      if (c <= lat && busy !== 1'b1) bz_ok = 1'b0;
      if (done === 1'b1 && seen == 0) begin seen = c; res = result; end
      if (c == lat + 1) begin
        chk({nm, " busy_low_after"}, 32'(busy), 32'd0);
        chk({nm, " done_one_cycle"}, 32'(done), 32'd0);
      end else begin
        @(posedge clk); #1;
      end
    end
    chk({nm, " done_cycle"}, 32'(seen), 32'(lat));
    chk({nm, " busy_span"}, 32'(bz_ok), 32'd1);
    chk({nm, " result"}, res, exp);
    last_exp = exp;
  endtask
  initial begin
    bit fseen;
    v[0]  = '{2'b01, 32'd100, 32'd7, 32'd14, 32'd14, 1'b0};
    v[1]  = '{2'b11, 32'd100, 32'd7, 32'd2, 32'd2, 1'b0};
    v[2]  = '{2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'h7FFFFFFC, 1'b0};
    v[3]  = '{2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'd1, 1'b0};
    v[4]  = '{2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0};
    v[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0};
    v[6]  = '{2'b01, 32'd5, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    v[7]  = '{2'b10, 32'd5, 32'd0, 32'd5, 32'd5, 1'b0};
    v[8]  = '{2'b00, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    v[9]  = '{2'b01, 32'hFFFFFFFF, 32'h80000000, 32'd1, 32'd1, 1'b0};
    v[10] = '{2'b11, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0};
    v[11] = '{2'b00, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd0, 1'b0};
    v[12] = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0};
    v[13] = '{2'b01, 32'd100, 32'd7, 32'd14, 32'd14, 1'b1};
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk_reset("reset");
    for (int i = 0; i < 14; i++) run_op(v[i], $sformatf("vec%0d", i));
    // flush mid-operation
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs1 = 32'd1000; rs2 = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    fseen = 1'b0;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush busy", 32'(busy), 32'd0);
    for (int c = 0; c < 4; c++) begin
      if (done) fseen = 1'b1;
      @(posedge clk); #1;
    end
    chk("flush no_done", 32'(fseen), 32'd0);
    chk("flush result_held", result, last_exp);
    run_op(v[2], "after_flush");
    // flush beats start in the same idle cycle
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b01; rs1 = 32'd5; rs2 = 32'd0;
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    chk("flush_start busy", 32'(busy), 32'd0);
    chk("flush_start done", 32'(done), 32'd0);
    chk("flush_start result", result, last_exp);
    // asynchronous reset mid-ITER
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs1 = 32'd100; rs2 = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_reset("async_reset");
    @(negedge clk) rst = 1'b0;
    run_op(v[9], "after_reset");
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
